// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice: ALU control codes and the
//   arbiter FSM state encoding.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
//   Combinational single-cycle integer ALU shared by the arbiter.
//   Ports:
//     a, b : WIDTH-bit operands
//     op   : OPW-bit alu_control code
//     y    : WIDTH-bit result (add/sub wrap modulo 2^WIDTH, unknown codes give 0)
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = $signed(a);
    assign sb = $signed(b);

    // Two's-complement add/sub in WIDTH bits gives the modulo wrap directly.
    always_comb begin
        y = '0;
        case (op)
            OPW'(ALU_ADD):   y = sa + sb;
            OPW'(ALU_SUB):   y = sa - sb;
            OPW'(ALU_XOR):   y = a ^ b;
            OPW'(ALU_PASSB): y = b;
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between the execute stage (requester 0) and
//   the branch/address-generation unit (requester 1). Round-robin arbitration,
//   valid/ready on the request and response sides. An accepted request is
//   latched, the ALU is evaluated for one cycle (EXEC), and the result is held
//   in the response register (RESP) until the consumer takes it.
//   Ports:
//     clk, rst_n                       : clock, asynchronous active-low reset
//     reqX_valid/ready/a/b/op (X=0,1)  : request channels
//     rsp_valid/ready/result/id        : response channel, id = owning requester
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id
);

    state_t           state;
    logic             last_grant;
    logic [WIDTH-1:0] lat_a_p0;
    logic [WIDTH-1:0] lat_b_p0;
    logic [OPW-1:0]   lat_op_p0;
    logic             lat_id_p0;
    logic             winner;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] alu_y;

    // Round-robin: a lone requester wins; on contention the one not granted last.
    always_comb begin
        winner = ~last_grant;
        if (req0_valid && !req1_valid) begin
            winner = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            winner = 1'b1;
        end
    end

    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);

    // rst_n gating keeps both readys low for the whole reset, not just after it.
    assign req0_ready = rst_n && can_accept && !winner && req0_valid;
    assign req1_ready = rst_n && can_accept &&  winner && req1_valid;
    assign accept     = req0_ready || req1_ready;

    alu_arbiter_alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a  (lat_a_p0),
        .b  (lat_b_p0),
        .op (lat_op_p0),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_a_p0   <= '0;
            lat_b_p0   <= '0;
            lat_op_p0  <= '0;
            lat_id_p0  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
        end else begin
            // Request latch: an accepted request is captured from IDLE or RESP.
            if (accept) begin
                lat_a_p0   <= winner ? req1_a  : req0_a;
                lat_b_p0   <= winner ? req1_b  : req0_b;
                lat_op_p0  <= winner ? req1_op : req0_op;
                lat_id_p0  <= winner;
                last_grant <= winner;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= EXEC;
                end
                // Response register: ALU output captured after one EXEC cycle.
                EXEC: begin
                    rsp_result <= alu_y;
                    rsp_id     <= lat_id_p0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed and randomized stimulus for alu_arbiter, checked every cycle
//   against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;

    int checks = 0;
    int errors = 0;

    // Reference model: expected responses in order, plus where the oldest
    // accepted operation is in its life (accepted / result visible).
    logic [WIDTH-1:0] q_res[$];
    logic             q_id[$];
    bit               pend;
    bit               vis;
    bit               last;
    bit               acc0, acc1;
    bit               held;
    logic [WIDTH-1:0] held_res;
    logic             held_id;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
        longint unsigned m;
        m = 64'd1 << WIDTH;
        case (op)
            4'd0:    return WIDTH'((longint'(a) + longint'(b)) % m);
            4'd1:    return WIDTH'((longint'(a) + m - longint'(b)) % m);
            4'd2:    return a ^ b;
            4'd3:    return b;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_res.delete();
        q_id.delete();
        pend = 0;
        vis  = 0;
        last = 1;
        held = 0;
        acc0 = 0;
        acc1 = 0;
    endtask

    // Checks outputs for the current cycle, then advances the model across
    // the coming rising edge.
    task automatic cycle_check();
        bit w, can, e0, e1, ev;
        ev  = pend && vis;
        can = !pend || (vis && rsp_ready);
        if (req0_valid && !req1_valid)      w = 0;
        else if (req1_valid && !req0_valid) w = 1;
        else                                w = !last;
        e0 = can && req0_valid && !w;
        e1 = can && req1_valid &&  w;
        check("req0_ready", WIDTH'(req0_ready), WIDTH'(e0));
        check("req1_ready", WIDTH'(req1_ready), WIDTH'(e1));
        check("one_ready",  WIDTH'(req0_ready & req1_ready), '0);
        check("rsp_valid",  WIDTH'(rsp_valid), WIDTH'(ev));
        if (ev) begin
            check("rsp_result", rsp_result, q_res[0]);
            check("rsp_id", WIDTH'(rsp_id), WIDTH'(q_id[0]));
        end
        if (held) begin
            check("hold_result", rsp_result, held_res);
            check("hold_id", WIDTH'(rsp_id), WIDTH'(held_id));
        end
        held     = ev && !rsp_ready;
        held_res = rsp_result;
        held_id  = rsp_id;
        acc0 = e0;
        acc1 = e1;
        if (pend && !vis) begin
            vis = 1;
        end else begin
            if (vis && rsp_ready) begin
                void'(q_res.pop_front());
                void'(q_id.pop_front());
                pend = 0;
                vis  = 0;
            end
            if (e0 || e1) begin
                q_res.push_back(w ? ref_alu(req1_a, req1_b, req1_op)
                                  : ref_alu(req0_a, req0_b, req0_op));
                q_id.push_back(w);
                pend = 1;
                vis  = 0;
                last = w;
            end
        end
    endtask

    // One clock: check at the falling edge, drive after the rising edge.
    // A requester whose operation was taken drops valid.
    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 0;
        model_reset();

        // Reset state, with a request pending to show ready is held low.
        req0_valid = 1'b1;
        #12;
        check("rst_req0_ready", WIDTH'(req0_ready), '0);
        check("rst_rsp_valid",  WIDTH'(rsp_valid), '0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_id",     WIDTH'(rsp_id), '0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request 5+3.
        req0_a = 5; req0_b = 3; req0_op = 4'b0000; req0_valid = 1; rsp_ready = 1;
        steps(4);

        // Subtract wrap 0-1.
        req1_a = 0; req1_b = 1; req1_op = 4'b0001; req1_valid = 1;
        steps(4);

        // Contention: req0 XOR, req1 PASSB.
        req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 4'b0010; req0_valid = 1;
        req1_a = 32'h55; req1_b = 32'h7;  req1_op = 4'b0011; req1_valid = 1;
        steps(8);

        // Undefined op, then back-pressure with req1 waiting.
        rsp_ready = 0;
        req0_a = 9; req0_b = 9; req0_op = 4'b0111; req0_valid = 1;
        steps(2);
        req1_a = 32'h1234; req1_b = 32'h1111; req1_op = 4'b0000; req1_valid = 1;
        steps(5);
        rsp_ready = 1;
        steps(4);

        // Asynchronous reset while a response is held.
        rsp_ready = 0;
        req0_a = 1; req0_b = 2; req0_op = 4'b0000; req0_valid = 1;
        steps(3);
        req0_valid = 1; req1_valid = 1;
        req1_a = 32'hA; req1_b = 32'h3; req1_op = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", WIDTH'(rsp_valid), '0);
        check("async_req0_ready", WIDTH'(req0_ready), '0);
        check("async_req1_ready", WIDTH'(req1_ready), '0);
        model_reset();
        @(posedge clk); #1;
        check("inrst_rsp_valid", WIDTH'(rsp_valid), '0);
        rst_n = 1'b1;
        rsp_ready = 1;
        @(negedge clk);
        check("post_rst_req0_wins", WIDTH'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        model_reset();
        pend = 1; vis = 0; last = 0;
        q_res.push_back(ref_alu(1, 2, 0));
        q_id.push_back(0);
        steps(6);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && ($urandom % 3 == 0)) begin
                req0_a = $urandom; req0_b = $urandom;
                req0_op = OPW'($urandom_range(0, 15));
                if ($urandom % 2 == 0) req0_op = OPW'($urandom_range(0, 3));
                req0_valid = 1;
            end
            if (!req1_valid && ($urandom % 3 == 0)) begin
                req1_a = $urandom; req1_b = $urandom;
                req1_op = OPW'($urandom_range(0, 15));
                if ($urandom % 2 == 0) req1_op = OPW'($urandom_range(0, 3));
                req1_valid = 1;
            end
            rsp_ready = ($urandom % 4 != 0);
            step();
        end

        // Drain, bounded.
        rsp_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (req0_valid || req1_valid || q_res.size() != 0) step();
        end
        check("drain_empty", WIDTH'(q_res.size()), '0);
        check("drain_valids", WIDTH'({req0_valid, req1_valid}), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle integer ALU between two requesters:
  - requester 0: execute stage;
  - requester 1: branch/address-generation unit.
- Round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Operands and op are latched, the ALU is driven for one cycle, and the result is held in a response register until it is consumed.
- Sits between the issue logic and the shared alu instance, which it contains.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, alu_control width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand a, requester 0
- req0_b  in  WIDTH  operand b, requester 0
- req0_op  in  OPW  alu_control code, requester 0
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  WIDTH  operand a, requester 1
- req1_b  in  WIDTH  operand b, requester 1
- req1_op  in  OPW  alu_control code, requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result this cycle
- rsp_result  out  WIDTH  ALU result
- rsp_id  out  1  requester that owns rsp_result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values (all state, immediately on rst_n low):
  - state=IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, last_grant=1;
  - latched operands and op = 0;
  - req0_ready/req1_ready = 0 while in reset.
- Handshake rules (both sides): transfer occurs on valid&ready in the same cycle.
  - A requester holds valid and its payload stable until ready.
  - Valid must not depend combinationally on ready.
  - The consumer holds rsp_ready independently of rsp_valid.
- Arbitration:
  - If only one reqX_valid is set, that requester is the winner.
  - If both are set, the winner is the requester that is not last_grant.
  - last_grant updates to the winner only on an accepted transfer.
  - With reset last_grant=1, requester 0 wins the first contention.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready).
  - reqX_ready = can_accept & winner==X & reqX_valid.
  - At most one ready is high per cycle.
- FSM:
  - IDLE: on an accepted transfer, latch a/b/op/id and go to EXEC. Otherwise stay.
  - EXEC: drive the ALU from the latched registers. At the clock edge, capture result into rsp_result and id into rsp_id, set rsp_valid=1, go to RESP. Always exactly one cycle.
  - RESP: rsp_valid=1 and the outputs are stable.
    - If rsp_ready with a simultaneous accepted request: latch the new request, go to EXEC, rsp_valid falls next cycle.
    - If rsp_ready with no request: go to IDLE, rsp_valid=0.
    - If rsp_ready is low: stay, and both readys stay low.
- Latency and throughput:
  - Accept at edge N; rsp_valid is high after edge N+1 (visible in cycle N+1→N+2).
  - Peak throughput is one operation per 2 cycles.
- ALU ops are passed unchanged. Required results:
  - 0000: a+b, 0001: a-b, 0010: a^b, 0011: b;
  - any other code gives 0, and this is not an error.
- Arithmetic: add and sub are modulo 2^WIDTH with wrap-around; no carry or overflow output.
- Reset mid-operation: any pending EXEC or RESP result is discarded and there is no response. last_grant returns to 1.
- Idle ALU inputs: when not in EXEC, the ALU inputs remain at the latched values; no glitch requirement.

Decomposition:
- Shared package:
  - ALU op constants ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_XOR=4'b0010, ALU_PASSB=4'b0011;
  - FSM state encodings IDLE/EXEC/RESP (2-bit).
- Sub-module: the existing alu (combinational), instantiated once inside alu_arbiter.
- The round-robin winner logic stays inline; it is too small for its own module.

Test Plan:
- Single request: req0 a=5, b=3, op=0000, rsp_ready=1.
  -> req0_ready=1 for 1 cycle; 2 cycles later rsp_valid=1, rsp_result=8, rsp_id=0.
- Subtract wrap: req1 a=0, b=1, op=0001.
  -> rsp_result=32'hFFFFFFFF, rsp_id=1.
- Contention after reset: both valid (req0 op=0010 a=F0 b=0F; req1 op=0011 b=7), rsp_ready=1.
  -> req0 served first with result FF, id 0; then req1 with result 7, id 1.
  -> No cycle has both readys high.
- Back-pressure: hold rsp_ready=0 for 5 cycles with req1 valid.
  -> rsp_valid, rsp_result and rsp_id are stable and req1_ready=0 throughout.
  -> On rsp_ready=1, req1_ready=1 in the same cycle.
- Undefined op: op=0111, a=9, b=9.
  -> rsp_result=0, rsp_valid asserts normally.
- Async reset in RESP: drop rst_n mid-cycle.
  -> rsp_valid=0 immediately, no stale response after release.
  -> Next contention is won by req0.
